branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  Sequencing controller for the pipeline's branch-decision path. Takes the
//  EX/MEM branch flag and ALU zero flag, plus the ID-stage load-use hazard flag.
//  Drives PCSrc to the fetch mux, PC/IF-ID write enables and pipeline-register flushes.
//  Keeps saturating performance counters for branches, taken branches and stall cycles.
// PARAMETERS
//  STALL_CYC  1   load-use stall length in cycles (1..15)
//  FLUSH_CYC  1   shadow cycles after a taken branch; branch/hazard inputs ignored (1..15)
//  CNT_W      16  performance counter width
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous reset, active-low
//  membranch    in   1      branch instruction in MEM stage (EX/MEM reg)
//  zero         in   1      ALU zero flag from EX/MEM reg
//  load_use     in   1      load-use hazard detected in ID stage
//  clr_cnt      in   1      synchronous clear of all perf counters
//  PCSrc        out  1      1 = fetch mux selects branch target
//  pc_write     out  1      PC register write enable
//  ifid_write   out  1      IF/ID register write enable
//  flush_ifid   out  1      zero IF/ID at next edge
//  flush_idex   out  1      zero ID/EX control (bubble) at next edge
//  flush_exmem  out  1      zero EX/MEM control at next edge
//  state        out  2      00 RUN, 01 STALL, 10 FLUSH (11 unused, recovers to RUN)
//  branch_cnt   out  CNT_W  branches evaluated
//  taken_cnt    out  CNT_W  branches taken
//  stall_cnt    out  CNT_W  cycles with pc_write=0 due to load-use
// BEHAVIOUR
//  - taken = membranch & zero. Control outputs combinational from state + inputs.
//  - Latency: zero-cycle. PCSrc/flushes assert in the same cycle taken is seen.
//  - Reset low, sampled at clk edge: state<=RUN, stall/flush counter<=0, perf counters<=0.
//  - While rst low, outputs forced: PCSrc=0, pc_write=0, ifid_write=0, all flushes=1.
//  - Defaults (no event): PCSrc=0, pc_write=1, ifid_write=1, flushes=0.
//  - RUN:
//    - taken: PCSrc=1, flush_ifid=flush_idex=flush_exmem=1, cnt<=FLUSH_CYC-1, ->FLUSH.
//    - else if load_use: pc_write=0, ifid_write=0, flush_idex=1.
//      If STALL_CYC==1 stay RUN; else cnt<=STALL_CYC-2, ->STALL.
//    - taken has priority over simultaneous load_use; that stall is dropped.
//  - STALL: pc_write=0, ifid_write=0, flush_idex=1.
//    - cnt==0 -> RUN, else cnt--. load_use ignored.
//    - taken mid-stall aborts the stall: RUN taken outputs (pc_write=1, PCSrc=1,
//      all flushes), cnt<=FLUSH_CYC-1, ->FLUSH.
//  - FLUSH: defaults except flush_ifid=flush_idex=1. membranch, zero, load_use ignored
//    (wrong-path bubbles). cnt==0 -> RUN, else cnt--.
//  - Total stall cycles = STALL_CYC; total shadow cycles after a taken branch = FLUSH_CYC.
//  - Counters:
//    - branch_cnt +1 when membranch=1 in RUN/STALL.
//    - taken_cnt +1 when taken in RUN/STALL.
//    - stall_cnt +1 each cycle a load-use stall holds pc_write=0.
//    - All saturate at 2^CNT_W-1; no wrap.
//    - clr_cnt overrides that cycle's increment; rst overrides clr_cnt.
//  - State 11 (illegal): defaults driven, ->RUN next edge.
// TESTING
//  1 Reset: rst=0 for 2 cycles, inputs=1 -> PCSrc=0, pc_write=0, flushes=1; state=00, counters=0 after release.
//  2 Taken: RUN, membranch=1, zero=1 one cycle -> that cycle PCSrc=1, 3 flushes=1; next cycle state=10; RUN after 1 cycle; branch_cnt=1, taken_cnt=1.
//  3 Not taken: membranch=1, zero=0 -> PCSrc=0, no flush, state stays 00; branch_cnt=1, taken_cnt=0.
//  4 Load-use, STALL_CYC=3: load_use=1 one cycle -> pc_write=0 for exactly 3 cycles, then 1; stall_cnt=3.
//  5 Abort, STALL_CYC=3: load_use, then taken in the 2nd stall cycle -> that cycle pc_write=1, PCSrc=1, state->10; stall_cnt=1.
//  6 Saturation, CNT_W=4: 20 taken branches 2 cycles apart -> taken_cnt=15; clr_cnt=1 with taken the same cycle -> 0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Sequencing controller for the branch-decision path of the pipeline.
//   It turns the EX/MEM branch/zero flags and the ID load-use flag into the
//   fetch-mux select, the PC and IF/ID write enables, and the pipeline flushes.
//   It also keeps saturating counters of branches, taken branches and
//   load-use stall cycles.
//
// Parameters
//   STALL_CYC  load-use stall length in cycles (1..15)
//   FLUSH_CYC  shadow cycles after a taken branch (1..15)
//   CNT_W      performance counter width
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   membranch    branch instruction in MEM stage
//   zero         ALU zero flag from EX/MEM
//   load_use     load-use hazard seen in ID
//   clr_cnt      synchronous clear of the performance counters
//   PCSrc        1 = fetch mux selects the branch target
//   pc_write     PC write enable
//   ifid_write   IF/ID write enable
//   flush_ifid   zero IF/ID at next edge
//   flush_idex   bubble ID/EX control at next edge
//   flush_exmem  zero EX/MEM control at next edge
//   state        00 RUN, 01 STALL, 10 FLUSH (11 recovers to RUN)
//   branch_cnt   branches evaluated
//   taken_cnt    branches taken
//   stall_cnt    cycles held by a load-use stall
module branch_hazard_ctrl #(
    parameter int unsigned STALL_CYC = 1,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             membranch,
    input  logic             zero,
    input  logic             load_use,
    input  logic             clr_cnt,
    output logic             PCSrc,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] STALL = 2'b01;
    localparam logic [1:0] FLUSH = 2'b10;

    // The RUN cycle that detects load_use is itself the first stall cycle,
    // so STALL only needs STALL_CYC-1 more cycles (counted down to 0).
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);
    localparam logic [3:0] STALL_RELOAD = (STALL_CYC > 1) ? 4'(STALL_CYC - 2) : '0;

    logic       taken;
    logic [1:0] nxt_state;
    logic [3:0] cnt;
    logic [3:0] nxt_cnt;
    logic       evaluating;   // branch inputs are live (RUN or STALL)
    logic       stall_hold;   // this cycle is held by a load-use stall

    assign taken = membranch & zero;

    always_comb begin
        PCSrc       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        nxt_state   = state;
        nxt_cnt     = cnt;
        evaluating  = 1'b0;
        stall_hold  = 1'b0;

        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else begin
            case (state)
                RUN, STALL: begin
                    evaluating = 1'b1;
                    if (taken) begin
                        // A taken branch wins over any stall, pending or new.
                        PCSrc       = 1'b1;
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                        nxt_cnt     = FLUSH_RELOAD;
                        nxt_state   = FLUSH;
                    end else if (state == STALL || load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        flush_idex = 1'b1;
                        stall_hold = 1'b1;
                        if (state == RUN) begin
                            if (STALL_CYC > 1) begin
                                nxt_cnt   = STALL_RELOAD;
                                nxt_state = STALL;
                            end
                        end else if (cnt == '0) begin
                            nxt_state = RUN;
                        end else begin
                            nxt_cnt = cnt - 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (cnt == '0) begin
                        nxt_state = RUN;
                    end else begin
                        nxt_cnt = cnt - 4'd1;
                    end
                end
                default: begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_cnt) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (evaluating && membranch && branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (evaluating && taken && taken_cnt != '1) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
            if (stall_hold && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT 1: STALL_CYC=3, FLUSH_CYC=1, CNT_W=4
    logic       mb1, z1, lu1, clr1;
    logic       pcsrc1, pcw1, ifidw1, fifid1, fidex1, fexmem1;
    logic [1:0] st1;
    logic [3:0] bc1, tc1, sc1;

    // DUT 2: STALL_CYC=1, FLUSH_CYC=2, CNT_W=8
    logic       mb2, z2, lu2, clr2;
    logic       pcsrc2, pcw2, ifidw2, fifid2, fidex2, fexmem2;
    logic [1:0] st2;
    logic [7:0] bc2, tc2, sc2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    branch_hazard_ctrl #(.STALL_CYC(3), .FLUSH_CYC(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .membranch(mb1), .zero(z1), .load_use(lu1),
        .clr_cnt(clr1), .PCSrc(pcsrc1), .pc_write(pcw1), .ifid_write(ifidw1),
        .flush_ifid(fifid1), .flush_idex(fidex1), .flush_exmem(fexmem1),
        .state(st1), .branch_cnt(bc1), .taken_cnt(tc1), .stall_cnt(sc1)
    );

    branch_hazard_ctrl #(.STALL_CYC(1), .FLUSH_CYC(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .membranch(mb2), .zero(z2), .load_use(lu2),
        .clr_cnt(clr2), .PCSrc(pcsrc2), .pc_write(pcw2), .ifid_write(ifidw2),
        .flush_ifid(fifid2), .flush_idex(fidex2), .flush_exmem(fexmem2),
        .state(st2), .branch_cnt(bc2), .taken_cnt(tc2), .stall_cnt(sc2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic in1(input logic m, input logic z, input logic l, input logic c);
        mb1 = m; z1 = z; lu1 = l; clr1 = c;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        in1(1, 1, 1, 1);
        mb2 = 1; z2 = 1; lu2 = 1; clr2 = 1;
        #1;

        // Reset: outputs forced regardless of inputs
        check_eq("rst_pcsrc",  32'(pcsrc1),  32'd0);
        check_eq("rst_pcw",    32'(pcw1),    32'd0);
        check_eq("rst_ifidw",  32'(ifidw1),  32'd0);
        check_eq("rst_flushes", 32'({fifid1, fidex1, fexmem1}), 32'h7);
        tick();
        tick();
        check_eq("rst_pcsrc2", 32'(pcsrc1), 32'd0);
        check_eq("rst_state",  32'(st1), 32'd0);
        check_eq("rst_bc",     32'(bc1), 32'd0);
        check_eq("rst_tc",     32'(tc1), 32'd0);
        rst = 1'b1;
        mb2 = 0; z2 = 0; lu2 = 0; clr2 = 0;
        in1(0, 0, 0, 0);
        check_eq("rel_state",  32'(st1), 32'd0);
        check_eq("rel_sc",     32'(sc1), 32'd0);
        check_eq("rel_pcw",    32'(pcw1), 32'd1);

        // Taken branch, inputs ignored in the shadow cycle
        in1(1, 1, 0, 0);
        check_eq("tk_pcsrc",   32'(pcsrc1), 32'd1);
        check_eq("tk_flushes", 32'({fifid1, fidex1, fexmem1}), 32'h7);
        check_eq("tk_pcw",     32'(pcw1), 32'd1);
        tick();
        in1(1, 1, 1, 0);
        check_eq("tk_state_flush", 32'(st1), 32'd2);
        check_eq("fl_pcsrc",   32'(pcsrc1), 32'd0);
        check_eq("fl_flushes", 32'({fifid1, fidex1, fexmem1}), 32'h6);
        check_eq("fl_pcw",     32'(pcw1), 32'd1);
        tick();
        in1(0, 0, 0, 0);
        check_eq("tk_state_run", 32'(st1), 32'd0);
        check_eq("tk_bc", 32'(bc1), 32'd1);
        check_eq("tk_tc", 32'(tc1), 32'd1);
        check_eq("tk_sc", 32'(sc1), 32'd0);

        // Not-taken branch
        in1(0, 0, 0, 1);
        tick();
        in1(1, 0, 0, 0);
        check_eq("nt_pcsrc",   32'(pcsrc1), 32'd0);
        check_eq("nt_flushes", 32'({fifid1, fidex1, fexmem1}), 32'h0);
        tick();
        in1(0, 0, 0, 0);
        check_eq("nt_state", 32'(st1), 32'd0);
        check_eq("nt_bc", 32'(bc1), 32'd1);
        check_eq("nt_tc", 32'(tc1), 32'd0);

        // Load-use stall of 3 cycles
        in1(0, 0, 0, 1);
        tick();
        in1(0, 0, 1, 0);
        check_eq("lu_pcw0",   32'(pcw1), 32'd0);
        check_eq("lu_ifidw0", 32'(ifidw1), 32'd0);
        check_eq("lu_flushes0", 32'({fifid1, fidex1, fexmem1}), 32'h2);
        tick();
        in1(0, 0, 0, 0);
        check_eq("lu_state1", 32'(st1), 32'd1);
        check_eq("lu_pcw1",   32'(pcw1), 32'd0);
        tick();
        check_eq("lu_state2", 32'(st1), 32'd1);
        check_eq("lu_pcw2",   32'(pcw1), 32'd0);
        tick();
        check_eq("lu_state3", 32'(st1), 32'd0);
        check_eq("lu_pcw3",   32'(pcw1), 32'd1);
        check_eq("lu_sc",     32'(sc1), 32'd3);

        // Taken branch aborts a stall in its 2nd cycle
        in1(0, 0, 0, 1);
        tick();
        in1(0, 0, 1, 0);
        tick();
        in1(1, 1, 0, 0);
        check_eq("ab_state",  32'(st1), 32'd1);
        check_eq("ab_pcw",    32'(pcw1), 32'd1);
        check_eq("ab_pcsrc",  32'(pcsrc1), 32'd1);
        check_eq("ab_flushes", 32'({fifid1, fidex1, fexmem1}), 32'h7);
        check_eq("ab_sc_mid", 32'(sc1), 32'd1);
        tick();
        in1(0, 0, 0, 0);
        check_eq("ab_state_flush", 32'(st1), 32'd2);
        check_eq("ab_sc", 32'(sc1), 32'd1);
        check_eq("ab_tc", 32'(tc1), 32'd1);
        tick();
        check_eq("ab_state_run", 32'(st1), 32'd0);

        // Saturation at 15 with CNT_W=4, then clear beats a same-cycle increment
        in1(0, 0, 0, 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            in1(1, 1, 0, 0);
            tick();
            in1(0, 0, 0, 0);
            tick();
        end
        check_eq("sat_tc", 32'(tc1), 32'd15);
        check_eq("sat_bc", 32'(bc1), 32'd15);
        in1(1, 1, 0, 1);
        tick();
        in1(0, 0, 0, 0);
        check_eq("clr_tc", 32'(tc1), 32'd0);
        check_eq("clr_bc", 32'(bc1), 32'd0);
        check_eq("clr_state", 32'(st1), 32'd2);
        tick();

        // DUT 2: single-cycle stall stays in RUN, two-cycle flush shadow
        lu2 = 1;
        #1;
        check_eq("d2_lu_pcw", 32'(pcw2), 32'd0);
        tick();
        lu2 = 0;
        #1;
        check_eq("d2_lu_state", 32'(st2), 32'd0);
        check_eq("d2_lu_pcw1",  32'(pcw2), 32'd1);
        check_eq("d2_sc",       32'(sc2), 32'd1);
        mb2 = 1; z2 = 1;
        #1;
        check_eq("d2_pcsrc", 32'(pcsrc2), 32'd1);
        tick();
        mb2 = 0; z2 = 0;
        #1;
        check_eq("d2_fl1", 32'(st2), 32'd2);
        tick();
        check_eq("d2_fl2", 32'(st2), 32'd2);
        tick();
        check_eq("d2_run", 32'(st2), 32'd0);
        check_eq("d2_tc",  32'(tc2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
